// File: rtl/dircc_node_mem_pkg.sv
// ---------------------------------------------------------------------------
// dircc_node_mem_pkg
//
// Purpose:
//   Shared definitions for the node processing-memory stream reader: the
//   sequencing FSM state type, default geometry of the dual-port processing
//   memory, and the descriptor range check used before any read is issued.
//
// Contents:
//   ADDR_W_DEFAULT      halfword address width of memory port s2
//   DEPTH_WORDS_DEFAULT number of halfwords in the processing memory
//   rd_state_t          reader FSM states
//   range_ok()          1 when a descriptor (addr, len) fits inside the memory
// ---------------------------------------------------------------------------
package dircc_node_mem_pkg;

    localparam int ADDR_W_DEFAULT      = 15;
    localparam int DEPTH_WORDS_DEFAULT = 20480;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_FIN   = 3'd4
    } rd_state_t;

    // A descriptor is good when it moves at least one halfword and its
    // exclusive end address stays inside the memory. The sum is formed one
    // bit wider than the operands so it can never wrap back into range.
    function automatic logic range_ok(input logic [31:0] addr,
                                      input logic [31:0] len,
                                      input logic [31:0] depth);
        logic [32:0] end_excl;
        end_excl = {1'b0, addr} + {1'b0, len};
        return (len != 32'd0) && (end_excl <= {1'b0, depth});
    endfunction

endpackage

// File: rtl/dircc_node_mem_rd_fifo.sv
// ---------------------------------------------------------------------------
// dircc_node_mem_rd_fifo
//
// Purpose:
//   Small synchronous FIFO holding read-return beats between the memory port
//   and the outbound stream. Each entry carries the data word plus the sop
//   and eop flags that were decided when the beat was pushed.
//
// Ports:
//   clk, reset   clock and synchronous active-high reset (flushes contents)
//   push         write push_data this cycle
//   push_data    entry to store
//   pop          remove the head entry this cycle
//   head         current head entry (meaningful only when not empty)
//   count        number of valid entries, 0..DEPTH
//   empty        count == 0
// ---------------------------------------------------------------------------
module dircc_node_mem_rd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 18
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] storage [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is still accepted when the head leaves in the
    // same cycle; the freed slot is the one being written.
    always_comb begin
        empty   = (count == '0);
        full    = (count == CNT_W'(DEPTH));
        do_pop  = pop & ~empty;
        do_push = push & (~full | do_pop);
        head    = storage[rd_ptr];
    end

    // Pointers and occupancy. DEPTH is a power of two, so the pointers wrap
    // naturally at their width.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage needs no reset: an entry is only ever read after it was
    // written, because the pointers and count are reset together.
    always_ff @(posedge clk) begin
        if (do_push) begin
            storage[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/dircc_node_mem_stream_reader.sv
// ---------------------------------------------------------------------------
// dircc_node_mem_stream_reader
//
// Purpose:
//   Avalon-MM read master on the 16-bit s2 port of the node's dual-port
//   processing memory. Takes a descriptor (first halfword address, length),
//   reads the buffer and sends it out as one Avalon-ST packet with
//   backpressure, so the CPU can hand a message buffer to the outbound path
//   without copying it.
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   cmd_valid/ready     descriptor handshake; cmd_addr, cmd_len descriptor
//   mem_*               Avalon-MM master towards s2 (read only, latency 1)
//   mem_readdata        read data, valid one cycle after mem_chipselect
//   out_valid/ready     stream handshake; out_data, out_sop, out_eop payload
//   busy                transfer in progress
//   done                one-cycle end-of-transfer pulse
//   err                 one-cycle pulse alongside done for a rejected descriptor
// ---------------------------------------------------------------------------
module dircc_node_mem_stream_reader
    import dircc_node_mem_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEFAULT,
    parameter int DATA_W      = 16,
    parameter int DEPTH_WORDS = DEPTH_WORDS_DEFAULT,
    parameter int LEN_W       = 16,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_clken,
    output logic              mem_write,
    output logic [1:0]        mem_byteenable,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sop,
    output logic              out_eop,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int FIFO_W = DATA_W + 2;

    rd_state_t          state;
    rd_state_t          state_next;

    logic [ADDR_W-1:0]  rd_addr;
    logic [LEN_W-1:0]   rd_left;
    logic [LEN_W-1:0]   out_left;
    logic [LEN_W-1:0]   push_left;
    logic               push_first;
    logic               inflight;
    logic               reject;

    logic               accept;
    logic               issue;
    logic               handshake;
    logic               last_handshake;
    logic               range_good;
    logic [CNT_W:0]     occupancy;

    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_empty;
    logic [FIFO_W-1:0]  fifo_head;
    logic [FIFO_W-1:0]  fifo_in;

    // Handshake and read-issue decisions. A read may only go out when the
    // FIFO has room for it counting the one return that may still be on its
    // way, since a return cannot be stalled once the strobe is issued.
    always_comb begin
        cmd_ready      = (state == ST_IDLE) & ~reset;
        accept         = cmd_valid & cmd_ready;
        occupancy      = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight};
        issue          = (state == ST_READ) && (rd_left != '0) &&
                         (occupancy < (CNT_W+1)'(FIFO_DEPTH));
        handshake      = ~fifo_empty & out_ready;
        last_handshake = handshake && (out_left == LEN_W'(1));
        range_good     = range_ok(32'(rd_addr), 32'(rd_left), 32'(DEPTH_WORDS));
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic. DRAIN leaves on the eop handshake itself so that
    // done follows the last beat by exactly one cycle.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = ST_CHECK;
                end
            end
            ST_CHECK: begin
                state_next = range_good ? ST_READ : ST_FIN;
            end
            ST_READ: begin
                if ((rd_left == '0) || (issue && (rd_left == LEN_W'(1)))) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if ((out_left == '0) || last_handshake) begin
                    state_next = ST_FIN;
                end
            end
            ST_FIN: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // FSM and stream outputs. The stream fields are forced to zero while the
    // FIFO is empty so nothing stale is visible after a flush.
    always_comb begin
        mem_chipselect = issue;
        mem_address    = issue ? rd_addr : '0;
        mem_clken      = 1'b1;
        mem_write      = 1'b0;
        mem_byteenable = 2'b11;
        mem_writedata  = '0;
        busy           = (state != ST_IDLE);
        done           = (state == ST_FIN);
        err            = (state == ST_FIN) & reject;
        out_valid      = ~fifo_empty;
        out_sop        = ~fifo_empty & fifo_head[FIFO_W-1];
        out_eop        = ~fifo_empty & fifo_head[FIFO_W-2];
        out_data       = fifo_empty ? '0 : fifo_head[DATA_W-1:0];
    end

    // Transfer bookkeeping. Three independent counters track the read side,
    // the push side (to place sop/eop on each beat) and the stream side (to
    // know when the last beat has been taken). inflight marks the cycle in
    // which a read return arrives; clearing it on reset discards that return.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_addr    <= '0;
            rd_left    <= '0;
            out_left   <= '0;
            push_left  <= '0;
            push_first <= 1'b0;
            inflight   <= 1'b0;
            reject     <= 1'b0;
        end else begin
            inflight <= issue;
            if (accept) begin
                rd_addr    <= cmd_addr;
                rd_left    <= cmd_len;
                out_left   <= cmd_len;
                push_left  <= cmd_len;
                push_first <= 1'b1;
                reject     <= 1'b0;
            end else begin
                if (state == ST_CHECK) begin
                    reject <= ~range_good;
                end
                if (issue) begin
                    rd_addr <= rd_addr + ADDR_W'(1);
                    rd_left <= rd_left - LEN_W'(1);
                end
                if (inflight) begin
                    push_left  <= push_left - LEN_W'(1);
                    push_first <= 1'b0;
                end
                if (handshake && (out_left != '0)) begin
                    out_left <= out_left - LEN_W'(1);
                end
            end
        end
    end

    // Each returned word is tagged with its packet position as it enters
    // the FIFO, so the stream side only has to present the head.
    assign fifo_in = {push_first, (push_left == LEN_W'(1)), mem_readdata};

    dircc_node_mem_rd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FIFO_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight),
        .push_data (fifo_in),
        .pop       (handshake),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_dircc_node_mem_stream_reader.sv
// ---------------------------------------------------------------------------
// tb_dircc_node_mem_stream_reader
//
// Purpose:
//   Self-checking bench for the processing-memory stream reader. A simple
//   s2 memory model answers reads one cycle after the strobe; a queue-based
//   model holds the beats and read addresses each descriptor must produce,
//   and a compare process checks the DUT against it every cycle.
// ---------------------------------------------------------------------------
module tb_dircc_node_mem_stream_reader;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 20480;
    localparam int LEN_W  = 16;
    localparam int FDEPTH = 4;

    typedef struct packed {
        logic [15:0] data;
        logic        sop;
        logic        eop;
    } beat_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [LEN_W-1:0]  cmd_len = '0;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_chipselect;
    logic              mem_clken;
    logic              mem_write;
    logic [1:0]        mem_byteenable;
    logic [DATA_W-1:0] mem_writedata;
    logic [DATA_W-1:0] mem_readdata = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [DATA_W-1:0] out_data;
    logic              out_sop;
    logic              out_eop;
    logic              busy;
    logic              done;
    logic              err;

    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;
    bit    model_en = 0;
    bit    rand_ready = 0;
    beat_t exp_beats[$];
    int    exp_reads[$];
    beat_t got_beats[$];
    int    reads_seen = 0;
    int    issued_total = 0;
    int    popped_total = 0;
    bit    prev_stall = 0;
    beat_t held;

    dircc_node_mem_stream_reader dut (
        .clk            (clk),
        .reset          (reset),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_addr       (cmd_addr),
        .cmd_len        (cmd_len),
        .mem_address    (mem_address),
        .mem_chipselect (mem_chipselect),
        .mem_clken      (mem_clken),
        .mem_write      (mem_write),
        .mem_byteenable (mem_byteenable),
        .mem_writedata  (mem_writedata),
        .mem_readdata   (mem_readdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_sop        (out_sop),
        .out_eop        (out_eop),
        .busy           (busy),
        .done           (done),
        .err            (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory image contents: a fixed scramble of the address.
    function automatic logic [15:0] img(input int a);
        return 16'(a) ^ 16'hC3A5;
    endfunction

    // s2 port model: data one cycle after the strobe, junk otherwise.
    always @(posedge clk) begin
        if (mem_chipselect) mem_readdata <= img(int'(mem_address));
        else                mem_readdata <= 16'hDEAD;
    end

    // Sink backpressure: ready always high, or low about 30% of cycles.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            out_ready = rand_ready ? ($urandom_range(0, 99) >= 30) : 1'b1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_ctrl"}, 32'({cmd_ready, mem_chipselect, out_valid, out_sop, out_eop, busy, done, err}), 32'd0);
        checkOutput({tag, "_mem_address"}, 32'(mem_address), 32'd0);
        checkOutput({tag, "_out_data"}, 32'(out_data), 32'd0);
        checkOutput({tag, "_mem_write"}, 32'({mem_write, mem_writedata}), 32'd0);
        checkOutput({tag, "_mem_const"}, 32'({mem_clken, mem_byteenable}), 32'b111);
    endtask

    // Compare process: every stream beat must match the model queue head,
    // stalled beats must hold, every read strobe must hit the next expected
    // address, and reads issued minus beats taken may never exceed the FIFO.
    always @(negedge clk) begin
        if (model_en) begin
            beat_t cur;
            cur = '{data: out_data, sop: out_sop, eop: out_eop};
            if (prev_stall) begin
                checkOutput("hold_valid", 32'(out_valid), 32'd1);
                checkOutput("hold_beat", 32'(cur), 32'(held));
            end
            if (out_valid) begin
                if (exp_beats.size() == 0) begin
                    checkOutput("spurious_beat", 32'(out_valid), 32'd0);
                end else begin
                    checkOutput("beat", 32'(cur), 32'(exp_beats[0]));
                    if (out_ready) begin
                        void'(exp_beats.pop_front());
                        got_beats.push_back(cur);
                        popped_total++;
                    end
                end
            end
            prev_stall = out_valid & ~out_ready;
            held = cur;
            if (mem_chipselect) begin
                if (exp_reads.size() == 0) begin
                    checkOutput("spurious_read", 32'(mem_chipselect), 32'd0);
                end else begin
                    checkOutput("read_addr", 32'(mem_address), 32'(exp_reads.pop_front()));
                end
                reads_seen++;
                issued_total++;
            end
            checkOutput("mem_write", 32'({mem_write, mem_writedata}), 32'd0);
            checkOutput("outstanding_le_depth", 32'(issued_total - popped_total <= FDEPTH), 32'd1);
        end
    end

    // Present one descriptor; the model queues are loaded from the plain
    // rule "len>0 and addr+len within memory". Optionally wait for done and
    // report its cycle relative to the accept cycle (cycle 0).
    task automatic applyStimulus(input int a, input int l, input bit wait_done,
                                 output int done_rel, output bit err_seen);
        int start;
        beat_t b;
        @(posedge clk);
        #1;
        got_beats.delete();
        reads_seen = 0;
        if ((l != 0) && (a + l <= DEPTH)) begin
            for (int i = 0; i < l; i++) begin
                b.data = img(a + i);
                b.sop  = (i == 0);
                b.eop  = (i == l - 1);
                exp_beats.push_back(b);
                exp_reads.push_back(a + i);
            end
        end
        checkOutput("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_addr  = ADDR_W'(a);
        cmd_len   = LEN_W'(l);
        start     = cyc;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        done_rel  = -1;
        err_seen  = 1'b0;
        if (wait_done) begin
            for (int k = 0; k < 2000; k++) begin
                @(negedge clk);
                if (done) begin
                    done_rel = cyc - start;
                    err_seen = err;
                    break;
                end
            end
            if (done_rel < 0) checkOutput("done_timeout", 32'(done), 32'd1);
        end
    endtask

    initial begin
        int  d;
        bit  e;

        #600000;
        $display("[TB] FAIL watchdog: got no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  d;
        bit  e;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        checkResetOutputs("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("cmd_ready_after_reset", 32'(cmd_ready), 32'd1);
        model_en = 1;

        // 8 beats from 0x0100 with ready held high.
        applyStimulus(32'h0100, 8, 1, d, e);
        checkOutput("t1_done_cycle", 32'(d), 32'd12);
        checkOutput("t1_err", 32'(e), 32'd0);
        checkOutput("t1_beats", 32'(got_beats.size()), 32'd8);
        if (got_beats.size() == 8) begin
            checkOutput("t1_first_data", 32'(got_beats[0].data), 32'hC2A5);
            checkOutput("t1_first_sop", 32'({got_beats[0].sop, got_beats[0].eop}), 32'b10);
            checkOutput("t1_last_eop", 32'({got_beats[7].sop, got_beats[7].eop}), 32'b01);
        end

        // Single beat at the very last halfword.
        applyStimulus(20479, 1, 1, d, e);
        checkOutput("t2_done_cycle", 32'(d), 32'd5);
        checkOutput("t2_err", 32'(e), 32'd0);
        checkOutput("t2_beats", 32'(got_beats.size()), 32'd1);
        if (got_beats.size() == 1) begin
            checkOutput("t2_beat", 32'(got_beats[0]), 32'({16'h8C5A, 2'b11}));
        end

        // One halfword past the end: rejected without any read.
        applyStimulus(20479, 2, 1, d, e);
        checkOutput("t3_done_cycle", 32'(d), 32'd2);
        checkOutput("t3_err", 32'(e), 32'd1);
        checkOutput("t3_reads", 32'(reads_seen), 32'd0);
        checkOutput("t3_beats", 32'(got_beats.size()), 32'd0);

        // Zero length: rejected.
        applyStimulus(5, 0, 1, d, e);
        checkOutput("t4_done_cycle", 32'(d), 32'd2);
        checkOutput("t4_err", 32'(e), 32'd1);
        checkOutput("t4_reads", 32'(reads_seen), 32'd0);

        // 32 beats under random backpressure.
        rand_ready = 1;
        applyStimulus(32'h2000, 32, 1, d, e);
        rand_ready = 0;
        checkOutput("t5_err", 32'(e), 32'd0);
        checkOutput("t5_beats", 32'(got_beats.size()), 32'd32);
        checkOutput("t5_reads", 32'(reads_seen), 32'd32);
        checkOutput("t5_done_not_early", 32'(d >= 36), 32'd1);

        // Reset in cycle 6 of a 16-beat transfer.
        applyStimulus(32'h0300, 16, 0, d, e);
        repeat (5) @(posedge clk);
        #1;
        model_en = 0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        checkResetOutputs("midreset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_beats.delete();
        exp_reads.delete();
        issued_total = 0;
        popped_total = 0;
        prev_stall = 0;
        model_en = 1;
        @(negedge clk);
        checkOutput("cmd_ready_after_midreset", 32'(cmd_ready), 32'd1);

        // Fresh 4-beat transfer after the reset.
        applyStimulus(32'h0400, 4, 1, d, e);
        checkOutput("t6_done_cycle", 32'(d), 32'd8);
        checkOutput("t6_err", 32'(e), 32'd0);
        checkOutput("t6_beats", 32'(got_beats.size()), 32'd4);
        if (got_beats.size() == 4) begin
            checkOutput("t6_first_data", 32'(got_beats[0].data), 32'hC7A5);
        end

        repeat (3) @(posedge clk);
        #1;
        checkOutput("final_model_empty", 32'(exp_beats.size() + exp_reads.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
